// File: rtl/micro_sequencer_pkg.sv
// Shared types and constants for the microcode sequencer.
// Microword field positions, branch conditions and FSM states.
package micro_sequencer_pkg;

  localparam int ADDR_W = 11;
  localparam int MW_W   = 41;

  localparam int JADDR_LSB = 0;
  localparam int JADDR_MSB = 10;
  localparam int COND_LSB  = 11;
  localparam int COND_MSB  = 13;
  localparam int ALU_LSB   = 14;
  localparam int ALU_MSB   = 17;
  localparam int WR_BIT    = 18;
  localparam int RD_BIT    = 19;

  typedef enum logic [2:0] {
    COND_NEXT = 3'b000,
    COND_JN   = 3'b001,
    COND_JZ   = 3'b010,
    COND_JV   = 3'b011,
    COND_JC   = 3'b100,
    COND_JI   = 3'b101,
    COND_JMP  = 3'b110,
    COND_DEC  = 3'b111
  } cond_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/micro_decode_addr.sv
// Maps an instruction register to its microcode dispatch address.
// Purely combinational; upper bit always set to select the decode region.
module micro_decode_addr (
  input  logic [31:0] IR_IN,
  output logic [10:0] ADDR_OUT
);

  always_comb begin
    ADDR_OUT = '0;
    unique case (IR_IN[31:30])
      2'b00:   ADDR_OUT = {1'b1, 2'b00, IR_IN[24:22], 5'b00000};
      2'b01:   ADDR_OUT = {1'b1, 2'b01, 8'h00};
      default: ADDR_OUT = {1'b1, IR_IN[31:30], IR_IN[24:19], 2'b00};
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Control-store address sequencer with memory-wait stall
// and instruction decode dispatch.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W = micro_sequencer_pkg::ADDR_W,
  parameter int MW_W   = micro_sequencer_pkg::MW_W
) (
  input  logic              CLOCK_50,
  input  logic              RESET_InHigh,
  input  logic [MW_W-1:0]   MW_IN,
  input  logic [31:0]       IR_IN,
  input  logic [3:0]        FLAGS_IN,
  input  logic              MEM_READY,
  output logic [ADDR_W-1:0] CSAI_OUT,
  output logic              STALL_OUT,
  output logic              DECODE_OUT
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   csai_q, csai_d;
  logic                decode_q, decode_d;
  logic [ADDR_W-1:0]   seq_addr, next_addr;
  logic [10:0]         jaddr;
  logic [10:0]         dec_addr;
  logic [2:0]          cond;
  logic                mem_acc;
  logic                take;
  logic                stall;

  assign jaddr   = MW_IN[JADDR_MSB:JADDR_LSB];
  assign cond    = MW_IN[COND_MSB:COND_LSB];
  assign mem_acc = MW_IN[RD_BIT] | MW_IN[WR_BIT];

  micro_decode_addr u_dec (
    .IR_IN    (IR_IN),
    .ADDR_OUT (dec_addr)
  );

  // Flags and IR are taken live, so a branch held in WAIT
  // sees the values present on the cycle it finally advances.
  always_comb begin
    take = 1'b0;
    unique case (cond)
      COND_JN:  take = FLAGS_IN[3];
      COND_JZ:  take = FLAGS_IN[2];
      COND_JV:  take = FLAGS_IN[1];
      COND_JC:  take = FLAGS_IN[0];
      COND_JI:  take = IR_IN[13];
      COND_JMP: take = 1'b1;
      default:  take = 1'b0;
    endcase
  end

  always_comb begin
    seq_addr  = csai_q + ADDR_W'(1);
    next_addr = take ? ADDR_W'(jaddr) : seq_addr;
    if (cond == COND_DEC) next_addr = ADDR_W'(dec_addr);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      state_q  <= ST_RUN;
      csai_q   <= '0;
      decode_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      csai_q   <= csai_d;
      decode_q <= decode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (mem_acc && !MEM_READY) state_d = ST_WAIT;
      ST_WAIT: if (MEM_READY) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall    = ((state_q == ST_WAIT) || mem_acc) && !MEM_READY;
    csai_d   = stall ? csai_q : next_addr;
    decode_d = !stall && (cond == COND_DEC);
  end

  assign CSAI_OUT   = csai_q;
  assign STALL_OUT  = stall;
  assign DECODE_OUT = decode_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed testbench for micro_sequencer.
// Hand-computed addresses, immediate assertions per check.
module tb_micro_sequencer;

  logic        clk;
  logic        rst;
  logic [40:0] mw;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        ready;
  logic [10:0] csai;
  logic        stall;
  logic        dec;

  int tests;
  int fails;

  localparam logic [31:0] IR_ADDCC = 32'h8000_0000 | (32'h10 << 19);

  micro_sequencer dut (
    .CLOCK_50     (clk),
    .RESET_InHigh (rst),
    .MW_IN        (mw),
    .IR_IN        (ir),
    .FLAGS_IN     (flags),
    .MEM_READY    (ready),
    .CSAI_OUT     (csai),
    .STALL_OUT    (stall),
    .DECODE_OUT   (dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] mk(input logic [2:0] c,
                                     input logic [10:0] ja,
                                     input logic rd);
    logic [40:0] w;
    w = '0;
    w[10:0]  = ja;
    w[13:11] = c;
    w[19]    = rd;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    mw    = '0;
    ir    = '0;
    flags = '0;
    ready = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_csai", csai, 0);
    chk("rst_stall", stall, 0);
    chk("rst_dec", dec, 0);

    mw = mk(3'b000, 11'd0, 1'b0);
    step(); chk("seq1", csai, 1);
    step(); chk("seq2", csai, 2);
    step(); chk("seq3", csai, 3);

    mw = mk(3'b110, 11'd1600, 1'b0);
    step(); chk("jmp1600", csai, 1600);
    mw = mk(3'b010, 11'h040, 1'b0);
    flags = 4'b0100;
    step(); chk("jz_taken", csai, 64);
    mw = mk(3'b110, 11'd1600, 1'b0);
    step();
    mw = mk(3'b010, 11'h040, 1'b0);
    flags = 4'b0000;
    step(); chk("jz_not", csai, 1601);

    mw = mk(3'b111, 11'd0, 1'b0);
    ir = IR_ADDCC;
    step(); chk("dec_addcc", csai, 1600);
    chk("dec_pulse", dec, 1);
    mw = mk(3'b000, 11'd0, 1'b0);
    step(); chk("seq_after_dec", csai, 1601);
    chk("dec_clear", dec, 0);

    mw = mk(3'b111, 11'd0, 1'b0);
    ir = 32'h0140_0000;
    step(); chk("dec_branch", csai, 1184);
    ir = 32'h4000_0000;
    step(); chk("dec_call", csai, 1280);

    ir = '0;
    mw = mk(3'b001, 11'd100, 1'b0); flags = 4'b1000;
    step(); chk("jn_taken", csai, 100);
    mw = mk(3'b011, 11'd200, 1'b0); flags = 4'b0000;
    step(); chk("jv_not", csai, 101);
    mw = mk(3'b100, 11'd300, 1'b0); flags = 4'b0001;
    step(); chk("jc_taken", csai, 300);
    mw = mk(3'b101, 11'd500, 1'b0); ir = 32'h0000_2000;
    step(); chk("ji_taken", csai, 500);
    mw = mk(3'b101, 11'd700, 1'b0); ir = '0;
    step(); chk("ji_not", csai, 501);

    flags = '0;
    mw = mk(3'b000, 11'd0, 1'b1);
    ready = 1'b0;
    #1 chk("wait_entry_stall", stall, 1);
    step(); chk("wait1_csai", csai, 501);
    chk("wait1_stall", stall, 1);
    step(); chk("wait2_csai", csai, 501);
    chk("wait2_stall", stall, 1);
    ready = 1'b1;
    #1 chk("ready_stall", stall, 0);
    chk("ready_csai", csai, 501);
    step(); chk("wait_adv", csai, 502);

    mw = mk(3'b010, 11'd900, 1'b1);
    ready = 1'b0; flags = 4'b0000;
    step(); chk("late_flag_hold", csai, 502);
    flags = 4'b0100; ready = 1'b1;
    step(); chk("late_flag_jz", csai, 900);

    mw = mk(3'b111, 11'd0, 1'b1);
    ir = IR_ADDCC; ready = 1'b0;
    step(); chk("dec_defer_csai", csai, 900);
    chk("dec_defer_pulse", dec, 0);
    ready = 1'b1;
    step(); chk("dec_after_wait", csai, 1600);
    chk("dec_after_pulse", dec, 1);

    mw = mk(3'b110, 11'd2047, 1'b0);
    step(); chk("jmp2047", csai, 2047);
    mw = mk(3'b000, 11'd0, 1'b0);
    step(); chk("wrap", csai, 0);

    mw = mk(3'b110, 11'd10, 1'b0);
    step(); chk("jmp10", csai, 10);
    mw = mk(3'b000, 11'd0, 1'b1); ready = 1'b0;
    step(); chk("pre_rst_wait", csai, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mw = mk(3'b000, 11'd0, 1'b0);
    #1 chk("rst_wait_csai", csai, 0);
    chk("rst_wait_stall", stall, 0);
    chk("rst_wait_dec", dec, 0);
    step(); chk("post_rst_seq", csai, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
